dualmem_stream_reader: RTL
==========================

Name: dualmem_stream_reader

Overview:
- Read-side initiator for one port of the team's dual-port block RAM: clk-synchronous, enable-qualified port, registered read address, read data valid the cycle after the address is issued, 8-bit default data.
- Given a base address and length, fetches consecutive words and presents them on a valid/ready output stream. Backpressure is absorbed without losing memory data.
- Sits between a shared buffer (e.g. a UART TX or framebuffer RAM written by the CPU on the other port) and a streaming consumer.

Parameters:
- rwidth, 13, memory address width; memory depth is 2^rwidth words
- dw, 8, data word width

Ports:
- clk  input  1  sole clock; also drives the attached memory port clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- base  input  rwidth  first word address, sampled with start
- len  input  rwidth+1  word count, 0..2^rwidth, sampled with start
- abort  input  1  synchronous cancel of the current transfer
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse after the last word is accepted
- mem_en  output  1  memory port enable (read strobe)
- mem_we  output  1  memory port write enable; constant 0
- mem_addr  output  rwidth  memory port address
- mem_din  output  dw  memory port write data; constant 0
- mem_dout  input  dw  memory port read data, valid the cycle after mem_en
- out_valid  output  1  stream data valid
- out_ready  input  1  stream consumer ready
- out_data  output  dw  stream data

Behaviour:
- Reset: state IDLE. busy, done, mem_en, out_valid = 0. mem_addr, out_data = 0. FIFO is empty. Internal counters are cleared.
- States:
  - IDLE: on start with len>0, go to RUN. Load addr=base, remaining=len.
  - IDLE: on start with len=0, stay IDLE and pulse done on the next cycle.
  - RUN: when remaining==0 and no read is in flight, go to DRAIN.
  - DRAIN: when the FIFO is empty, go to IDLE and pulse done in the following cycle.
- start while busy is ignored.
- Output buffer: 2-entry FIFO; out_valid = FIFO not empty; out_data = head entry, registered.
- Read issue:
  - mem_en is combinational from registered state. It is high in RUN when remaining>0 and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - On issue: addr increments modulo 2^rwidth (wraps to 0 past the top address), remaining decrements, and inflight is set for the next cycle.
  - Sustains one word per cycle when out_ready is held high.
- Capture: in the cycle after an issue, mem_dout is written into the FIFO tail. It is sampled exactly once, in that cycle. A later change of the RAM contents via the other port does not affect captured words.
- Simultaneous push and pop on a full or non-empty FIFO is legal; the count is unchanged.
- Latency:
  - start in cycle 0 gives mem_en in cycle 1 and first out_valid in cycle 3.
  - Words are emitted in address order, with no gaps while out_ready stays high.
- out_data is held stable while out_valid & !out_ready.
- done goes high the cycle after the handshake of word len, for 1 cycle. busy drops in the same cycle done rises.
- abort:
  - In any non-IDLE state, the next edge gives IDLE, an empty FIFO, inflight cleared, out_valid=0, and no done.
  - A read in flight at abort is discarded.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins, no transfer starts.
- rst mid-transfer behaves like abort, with all outputs returned to their reset values.
- len = 2^rwidth reads every word once, starting at base and wrapping.

Test Plan:
- Memory preloaded mem[k]=k[7:0]; start, base=0x010, len=4, out_ready=1 -> mem_en cycles 1-4 at addr 0x010-0x013; out_data 0x10,0x11,0x12,0x13 on cycles 3-6; done pulse cycle 7; busy low cycle 7.
- Same transfer with out_ready toggling 1,0,0,1,... -> all 4 words in order with none duplicated or lost; out_data stable while stalled; fifo_count never exceeds 2; mem_en low whenever a further issue would overflow.
- base=0x1FFE, len=4 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001; data 0xFE,0xFF,0x00,0x01.
- start with len=0 -> mem_en never high, out_valid never high, done pulse the following cycle, busy stays 0.
- abort during the 3rd word of len=8 with out_ready=0 -> next cycle: busy=0, out_valid=0, no done; new start base=0x020 len=2 then yields exactly 0x20,0x21.
- rst asserted in RUN with FIFO full -> next cycle all outputs 0. start asserted in the same cycle as rst is ignored.

Source files
------------

// File: rtl/dualmem_stream_reader.sv
`timescale 1ns/1ps
// dualmem_stream_reader
// Reads `len` consecutive words from one port of a dual-port block RAM,
// starting at `base` and wrapping at the top address, and streams them out
// on a valid/ready interface. A 2-entry output FIFO absorbs backpressure.
// Reads are only issued when the FIFO is certain to have room, so no read
// data is ever lost.
module dualmem_stream_reader #(
  parameter int rwidth = 13,
  parameter int dw     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [rwidth-1:0] base,
  input  logic [rwidth:0]   len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [rwidth-1:0] mem_addr,
  output logic [dw-1:0]     mem_din,
  input  logic [dw-1:0]     mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [dw-1:0]     out_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [rwidth-1:0] addr;
  logic [rwidth:0]   remaining;
  logic              inflight;
  logic              done_q;

  logic [dw-1:0]     fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_count;

  logic              pop;
  logic              push;
  logic [2:0]        occupancy;
  logic              last_pop;

  // Stream side: head of the FIFO is presented directly from its register.
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  // The word read last cycle lands in the FIFO at the coming edge.
  assign push      = inflight;

  // Slots that will be taken after this edge if no new read is issued.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  // Issue a read only when the word it returns is guaranteed a FIFO slot.
  assign mem_en    = (state == S_RUN) && (remaining != '0) && (occupancy < 3'd2);

  // The final word of the transfer is being accepted this cycle.
  assign last_pop  = pop && (fifo_count == 2'd1) && !inflight && (remaining == '0);

  assign mem_we    = 1'b0;
  assign mem_din   = '0;
  assign mem_addr  = addr;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  // Transfer control, read issue, FIFO capture and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      done_q     <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      // NOTE: the FIFO storage is reset as well because its head drives
      // out_data directly; only two words, and it keeps out_data at zero.
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the pre-edge values of state, counters and pointers.
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (len == '0) begin
              done_q <= 1'b1;
            end else begin
              state     <= S_RUN;
              addr      <= base;
              remaining <= len;
            end
          end
        end
        default: begin
          if (abort) begin
            state      <= S_IDLE;
            remaining  <= '0;
            inflight   <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
          end else begin
            inflight <= mem_en;
            if (mem_en) begin
              addr      <= addr + rwidth'(1);
              remaining <= remaining - (rwidth + 1)'(1);
            end
            if (push) begin
              fifo_mem[wr_ptr] <= mem_dout;
              wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
            if (last_pop) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else if (state == S_RUN && remaining == '0 && !inflight) begin
              state <= S_DRAIN;
            end
          end
        end
      endcase
    end
  end

endmodule
